// File: rtl/regmap_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// regmap_access_arbiter_if
// One requester's register-map access channel.
//   req   : request, held high until ack
//   wr    : access type, 1 = write, 0 = read
//   addr  : target cell address
//   wdata : write data
//   ack   : one-cycle completion pulse
//   err   : out-of-range address flag, valid with ack
//   rdata : read data, valid with ack and held until the next read completes
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface regmap_access_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, wr, addr, wdata, input ack, err, rdata);
    modport slave  (input req, wr, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/regmap_access_arbiter.sv
// ---------------------------------------------------------------------------
// regmap_access_arbiter
// Shares the register-map cell array between master 0 (host) and master 1
// (sequencer). Requests are arbitrated round-robin and serialised; each
// access is decoded into a one-hot cell write enable or a read of the
// addressed cell's readback after RD_LAT cycles.
//   clk_i        : clock
//   rstb_i       : asynchronous active-low reset
//   m0, m1       : requester channels (slave modport)
//   cell_we_o    : one-hot registered write enable to the cells
//   cell_wdata_o : write data broadcast to all cells
//   cell_rdata_i : concatenated readback, cell k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy_o       : high while an access is in progress
// ---------------------------------------------------------------------------
module regmap_access_arbiter #(
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                           clk_i,
    input  logic                           rstb_i,
    regmap_access_arbiter_if.slave         m0,
    regmap_access_arbiter_if.slave         m1,
    output logic [NUM_REGS-1:0]            cell_we_o,
    output logic [DATA_WIDTH-1:0]          cell_wdata_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] cell_rdata_i,
    output logic                           busy_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, ACK = 2'd3} state_t;

    state_t                  state_r, state_nxt_s;
    logic                    gnt_r;          // granted master index
    logic                    last_grant_r;   // round-robin pointer
    logic                    wr_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [3:0]              cnt_r;
    logic [NUM_REGS-1:0]     cell_we_r;
    logic [DATA_WIDTH-1:0]   cell_wdata_r;
    logic                    ack0_r, ack1_r, err0_r, err1_r, busy_r;
    logic [DATA_WIDTH-1:0]   rdata0_r, rdata1_r;

    logic                    grant_s, sel_s, sel_wr_s, done_s, in_range_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s, rd_sel_s;
    logic [NUM_REGS-1:0]     we_dec_s;

    // Request selection: a lone request wins, contention goes to the master not served last.
    always_comb begin
        grant_s = m0.req | m1.req;
        if (m0.req && m1.req) begin
            sel_s = ~last_grant_r;
        end else if (m0.req) begin
            sel_s = 1'b0;
        end else begin
            sel_s = 1'b1;
        end
        if (sel_s) begin
            sel_wr_s    = m1.wr;
            sel_addr_s  = m1.addr;
            sel_wdata_s = m1.wdata;
        end else begin
            sel_wr_s    = m0.wr;
            sel_addr_s  = m0.addr;
            sel_wdata_s = m0.wdata;
        end
    end

    // Address decode: one-hot enable from the incoming address, readback mux from the latched one.
    always_comb begin
        we_dec_s   = '0;
        rd_sel_s   = '0;
        in_range_s = (32'(addr_r) < 32'(NUM_REGS));
        for (int k = 0; k < NUM_REGS; k++) begin
            we_dec_s[k] = (sel_addr_s == ADDR_WIDTH'(k));
            if (addr_r == ADDR_WIDTH'(k)) begin
                rd_sel_s = cell_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rd_sel_s = rd_sel_s;
            end
        end
    end

    // Next-state logic; done_s marks the cycle whose closing edge loads ack/err/rdata.
    always_comb begin
        state_nxt_s = state_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = sel_wr_s ? WR : RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR: begin
                state_nxt_s = ACK;
                done_s      = 1'b1;
            end
            RD: begin
                if (cnt_r == 4'(RD_LAT)) begin
                    state_nxt_s = ACK;
                    done_s      = 1'b1;
                end else begin
                    state_nxt_s = RD;
                end
            end
            ACK:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched request fields and all registered outputs.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_r      <= IDLE;
            gnt_r        <= 1'b0;
            last_grant_r <= 1'b1;
            wr_r         <= 1'b0;
            addr_r       <= '0;
            cnt_r        <= 4'd0;
            cell_we_r    <= '0;
            cell_wdata_r <= '0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            cell_we_r <= '0;
            if (state_r == IDLE && grant_s) begin
                gnt_r        <= sel_s;
                last_grant_r <= sel_s;
                wr_r         <= sel_wr_s;
                addr_r       <= sel_addr_s;
                cnt_r        <= 4'd1;
                if (sel_wr_s) begin
                    // Out-of-range addresses decode to an all-zero enable.
                    cell_we_r    <= we_dec_s;
                    cell_wdata_r <= sel_wdata_s;
                end
            end else if (state_r == RD) begin
                cnt_r <= cnt_r + 4'd1;
            end
            ack0_r <= done_s & ~gnt_r;
            ack1_r <= done_s &  gnt_r;
            err0_r <= done_s & ~gnt_r & ~in_range_s;
            err1_r <= done_s &  gnt_r & ~in_range_s;
            if (done_s && !wr_r) begin
                if (gnt_r) begin
                    rdata1_r <= in_range_s ? rd_sel_s : '0;
                end else begin
                    rdata0_r <= in_range_s ? rd_sel_s : '0;
                end
            end
        end
    end

    assign m0.ack       = ack0_r;
    assign m0.err       = err0_r;
    assign m0.rdata     = rdata0_r;
    assign m1.ack       = ack1_r;
    assign m1.err       = err1_r;
    assign m1.rdata     = rdata1_r;
    assign cell_we_o    = cell_we_r;
    assign cell_wdata_o = cell_wdata_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regmap_access_arbiter
// Directed bench: one arbiter with RD_LAT = 1 and one with RD_LAT = 4.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_regmap_access_arbiter;
    localparam int NR = 16;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    regmap_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a0 ();
    regmap_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a1 ();
    regmap_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
    regmap_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

    logic [NR*DW-1:0] cell_rd, cell_rd4;
    logic [NR-1:0]    we, we4;
    logic [DW-1:0]    wd, wd4;
    logic             busy, busy4;

    regmap_access_arbiter #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
        .clk_i(clk), .rstb_i(rstb), .m0(a0), .m1(a1),
        .cell_we_o(we), .cell_wdata_o(wd), .cell_rdata_i(cell_rd), .busy_o(busy));

    regmap_access_arbiter #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(4)) dut4 (
        .clk_i(clk), .rstb_i(rstb), .m0(b0), .m1(b1),
        .cell_we_o(we4), .cell_wdata_o(wd4), .cell_rdata_i(cell_rd4), .busy_o(busy4));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a0(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a0.req = r; a0.wr = w; a0.addr = ad; a0.wdata = d;
    endtask

    task automatic set_a1(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a1.req = r; a1.wr = w; a1.addr = ad; a1.wdata = d;
    endtask

    initial begin
        int got;
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        set_a1(1'b0, 1'b0, 8'd0, 16'h0000);
        b0.req = 1'b0; b0.wr = 1'b0; b0.addr = 8'd0; b0.wdata = 16'h0000;
        b1.req = 1'b0; b1.wr = 1'b0; b1.addr = 8'd0; b1.wdata = 16'h0000;
        for (int k = 0; k < NR; k++) begin
            cell_rd[k*DW +: DW]  = 16'h1000 + 16'(k);
            cell_rd4[k*DW +: DW] = 16'h1000 + 16'(k);
        end
        cell_rd[5*DW +: DW]  = 16'h1234;
        cell_rd4[9*DW +: DW] = 16'h1111;

        // Reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", we, 16'h0000);
        chk("rst_acks", {a0.ack, a1.ack, a0.err, a1.err}, 4'b0000);
        chk("rst_rdata", {a0.rdata, a1.rdata}, 32'h0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        tick();

        // Master 0 writes 0xA5C3 to cell 3
        set_a0(1'b1, 1'b1, 8'd3, 16'hA5C3);
        tick();
        chk("wr_we", we, 16'h0008);
        chk("wr_wdata", wd, 16'hA5C3);
        chk("wr_early_ack", a0.ack, 1'b0);
        chk("wr_busy", busy, 1'b1);
        tick();
        chk("wr_we_one_cycle", we, 16'h0000);
        chk("wr_ack", {a0.ack, a0.err, a1.ack}, 3'b100);
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();
        chk("wr_ack_pulse", {a0.ack, busy}, 2'b00);

        // Master 1 reads cell 5
        set_a1(1'b1, 1'b0, 8'd5, 16'h0000);
        tick();
        chk("rd_early_ack", {a1.ack, we}, 17'h0);
        tick();
        chk("rd_ack", {a1.ack, a1.err, a0.ack}, 3'b100);
        chk("rd_data", a1.rdata, 16'h1234);
        chk("rd_no_we", we, 16'h0000);
        set_a1(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();

        // Continuous contention, four writes each: acks alternate starting with m0
        set_a0(1'b1, 1'b1, 8'd1, 16'h0101);
        set_a1(1'b1, 1'b1, 8'd2, 16'h0202);
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            tick();
            if (a0.ack || a1.ack) begin
                chk("rr_order", {a0.ack, a1.ack}, (got % 2 == 0) ? 2'b10 : 2'b01);
                got++;
                if (got == 8) begin
                    set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
                    set_a1(1'b0, 1'b0, 8'd0, 16'h0000);
                end
            end
        end
        chk("rr_count", got, 8);
        tick();
        tick();

        // Out-of-range write to address 20
        set_a0(1'b1, 1'b1, 8'd20, 16'hBEEF);
        tick();
        chk("oor_wr_we", {we, busy}, 17'h00001);
        tick();
        chk("oor_wr_ack", {a0.ack, a0.err, we}, 18'h20000 | 18'h10000);
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();
        chk("oor_err_pulse", {a0.ack, a0.err}, 2'b00);

        // Master 0 reads cell 7, then address 20
        set_a0(1'b1, 1'b0, 8'd7, 16'h0000);
        tick();
        tick();
        chk("rd7", {a0.ack, a0.err, a0.rdata}, {2'b10, 16'h1007});
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();
        chk("rd7_hold", a0.rdata, 16'h1007);
        set_a0(1'b1, 1'b0, 8'd20, 16'h0000);
        tick();
        tick();
        chk("oor_rd", {a0.ack, a0.err, a0.rdata}, {2'b11, 16'h0000});
        chk("m1_rdata_hold", a1.rdata, 16'h1234);
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();

        // Reset asserted during a master 0 read
        set_a0(1'b1, 1'b0, 8'd5, 16'h0000);
        tick();
        chk("pre_rst_busy", busy, 1'b1);
        rstb = 1'b0;
        #1;
        chk("mid_rst_outs", {busy, a0.ack, a1.ack, we}, 19'h0);
        chk("mid_rst_data", {a1.rdata, wd}, 32'h0);
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();
        tick();
        rstb = 1'b1;
        tick();
        chk("post_rst_no_ack", {a0.ack, a1.ack, busy}, 3'b000);
        set_a0(1'b1, 1'b0, 8'd4, 16'h0000);
        set_a1(1'b1, 1'b0, 8'd6, 16'h0000);
        tick();
        tick();
        chk("post_rst_m0_first", {a0.ack, a1.ack}, 2'b10);
        chk("post_rst_rdata", a0.rdata, 16'h1004);
        set_a0(1'b0, 1'b0, 8'd0, 16'h0000);
        set_a1(1'b0, 1'b0, 8'd0, 16'h0000);
        tick();
        tick();
        tick();

        // RD_LAT = 4: value changes during the read, the 4th RD cycle's value is taken
        b0.req = 1'b1; b0.wr = 1'b0; b0.addr = 8'd9;
        tick();
        chk("lat4_c1", {b0.ack, busy4}, 2'b01);
        tick();
        cell_rd4[9*DW +: DW] = 16'h2222;
        chk("lat4_c2", b0.ack, 1'b0);
        tick();
        chk("lat4_c3", b0.ack, 1'b0);
        tick();
        cell_rd4[9*DW +: DW] = 16'h3333;
        chk("lat4_c4", b0.ack, 1'b0);
        tick();
        chk("lat4_ack", {b0.ack, b0.err, b0.rdata}, {2'b10, 16'h3333});
        b0.req = 1'b0;
        tick();
        chk("lat4_ack_pulse", b0.ack, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
